rr_onehot_sel4: RTL and testbench

RR_ONEHOT_SEL4 -- requirements
Module: rr_onehot_sel4

---
 rtl/rr_onehot_sel4_pkg.sv | 26 ++
 rtl/rr_onehot_sel4_if.sv | 34 +++
 rtl/rr_pick4.sv | 28 ++
 rtl/rr_onehot_sel4.sv | 108 ++++++++++
 tb/tb_rr_onehot_sel4.sv | 141 ++++++++++++++
 5 files changed

// File: rtl/rr_onehot_sel4_pkg.sv
// Shared definitions for the one-hot mux-select arbiter family:
// port count, FSM state encoding and the one-hot to binary index helper.
package rr_onehot_sel4_pkg;

    localparam int N_PORTS = 4;
    localparam int IDX_W   = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // OR-reduction encoder: correct for one-hot or all-zero inputs, which are
    // the only values the arbiter ever presents.
    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [N_PORTS-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (oh[i]) begin
                idx = idx | IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_onehot_sel4_if.sv
// Request/grant bundle between requesters and the one-hot select arbiter.
// Handshake: req is level-held by each port; a grant lasts while select has the
// port's bit set; the owner ends it with a one-cycle done pulse or by dropping req.
interface rr_onehot_sel4_if import rr_onehot_sel4_pkg::*; ();

    logic [N_PORTS-1:0] req;
    logic               done;
    logic [N_PORTS-1:0] select;
    logic [IDX_W-1:0]   sel_idx;
    logic               busy;
    logic               timeout;
    state_t             dbg_state;

    modport master (
        output req,
        output done,
        input  select,
        input  sel_idx,
        input  busy,
        input  timeout,
        input  dbg_state
    );

    modport slave (
        input  req,
        input  done,
        output select,
        output sel_idx,
        output busy,
        output timeout,
        output dbg_state
    );

endinterface

// File: rtl/rr_pick4.sv
// Combinational rotating-priority pick: first set req bit scanning upward
// from ptr (modulo 4), returned one-hot.
module rr_pick4 import rr_onehot_sel4_pkg::*; (
    input  logic [N_PORTS-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [N_PORTS-1:0] grant,
    output logic               any
);

    logic [IDX_W-1:0] idx;
    logic             found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            idx = ptr + IDX_W'(i);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/rr_onehot_sel4.sv
// Round-robin arbiter producing a registered one-hot mux select with a
// mandatory idle cycle between grants and a bounded hold time.
module rr_onehot_sel4 import rr_onehot_sel4_pkg::*; #(
    parameter int MAX_HOLD = 15
) (
    input logic              clk,
    input logic              rst_n,
    rr_onehot_sel4_if.slave  bus
);

    localparam int               CNT_W     = $clog2(MAX_HOLD + 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N_PORTS-1:0] select_q, select_d;
    logic [IDX_W-1:0]   sel_idx_q, sel_idx_d;
    logic               busy_q, busy_d;
    logic               timeout_q, timeout_d;

    logic [N_PORTS-1:0] pick_grant;
    logic               pick_any;
    logic               owner_req;
    logic               hold_hit;
    logic               release_now;

    rr_pick4 u_pick (
        .req   (bus.req),
        .ptr   (ptr_q),
        .grant (pick_grant),
        .any   (pick_any)
    );

    // Only the owner's request line matters once granted; other ports are ignored.
    assign owner_req   = |(bus.req & select_q);
    assign hold_hit    = (cnt_q == HOLD_LAST);
    assign release_now = bus.done || !owner_req || hold_hit;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        select_d  = select_q;
        sel_idx_d = sel_idx_q;
        busy_d    = busy_q;
        timeout_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    state_d   = ST_GRANT;
                    select_d  = pick_grant;
                    sel_idx_d = onehot_to_idx(pick_grant);
                    busy_d    = 1'b1;
                    cnt_d     = '0;
                end
            end
            ST_GRANT: begin
                if (release_now) begin
                    state_d   = ST_IDLE;
                    select_d  = '0;
                    sel_idx_d = '0;
                    busy_d    = 1'b0;
                    cnt_d     = '0;
                    ptr_d     = sel_idx_q + IDX_W'(1);
                    // Forced release is flagged only when nothing else ended the grant.
                    timeout_d = hold_hit && !bus.done && owner_req;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d   = ST_IDLE;
                select_d  = '0;
                sel_idx_d = '0;
                busy_d    = 1'b0;
                cnt_d     = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            cnt_q     <= '0;
            select_q  <= '0;
            sel_idx_q <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            select_q  <= select_d;
            sel_idx_q <= sel_idx_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.select    = select_q;
    assign bus.sel_idx   = sel_idx_q;
    assign bus.busy      = busy_q;
    assign bus.timeout   = timeout_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_rr_onehot_sel4.sv
// Directed bench for rr_onehot_sel4 (MAX_HOLD=4): driver pushes per-cycle
// expected outputs, a monitor pops and compares after every rising edge.
module tb_rr_onehot_sel4;
    import rr_onehot_sel4_pkg::*;

    logic clk;
    logic rst_n;

    rr_onehot_sel4_if bus ();

    rr_onehot_sel4 #(.MAX_HOLD(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          tests_run = 0;
    int          tests_failed = 0;
    logic [7:0]  exp_q[$];
    string       tag_q[$];
    logic [7:0]  got;
    logic [7:0]  exp_v;
    string       tag_v;

    // driver: apply inputs at the falling edge, queue the outputs expected after the next rising edge
    task automatic step(input logic r, input logic [3:0] rq, input logic d,
                        input logic [3:0] es, input logic [1:0] ei,
                        input logic eb, input logic et, input string tag);
        rst_n    = r;
        bus.req  = rq;
        bus.done = d;
        exp_q.push_back({es, ei, eb, et});
        tag_q.push_back(tag);
        @(negedge clk);
    endtask

    // scoreboard monitor
    always @(posedge clk) begin
        #1;
        tests_run++;
        if ($countones(bus.select) > 1) begin
            tests_failed++;
            $display("FAIL onehot: select=%b is neither one-hot nor zero", bus.select);
        end
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            tag_v = tag_q.pop_front();
            got   = {bus.select, bus.sel_idx, bus.busy, bus.timeout};
            tests_run++;
            if (got !== exp_v) begin
                tests_failed++;
                $display("FAIL %s: got sel=%b idx=%0d busy=%b to=%b, expected sel=%b idx=%0d busy=%b to=%b",
                         tag_v, got[7:4], got[3:2], got[1], got[0],
                         exp_v[7:4], exp_v[3:2], exp_v[1], exp_v[0]);
            end
        end
    end

    initial begin
        rst_n    = 1'b0;
        bus.req  = 4'b0000;
        bus.done = 1'b0;
        @(negedge clk);

        // reset state
        step(0, 4'b0000, 0, 4'b0000, 2'd0, 0, 0, "reset0");
        step(0, 4'b0001, 1, 4'b0000, 2'd0, 0, 0, "reset1");

        // single request, done release
        step(1, 4'b0001, 0, 4'b0001, 2'd0, 1, 0, "req0_grant");
        step(1, 4'b0001, 1, 4'b0000, 2'd0, 0, 0, "req0_done");
        step(1, 4'b0000, 0, 4'b0000, 2'd0, 0, 0, "idle_stay");
        step(1, 4'b0000, 1, 4'b0000, 2'd0, 0, 0, "done_in_idle");

        // all ports requesting, rotation with one idle cycle between grants
        step(0, 4'b0000, 0, 4'b0000, 2'd0, 0, 0, "rst_a");
        step(1, 4'b1111, 0, 4'b0001, 2'd0, 1, 0, "rr_g0");
        step(1, 4'b1111, 1, 4'b0000, 2'd0, 0, 0, "rr_i0");
        step(1, 4'b1111, 0, 4'b0010, 2'd1, 1, 0, "rr_g1");
        step(1, 4'b1111, 1, 4'b0000, 2'd0, 0, 0, "rr_i1");
        step(1, 4'b1111, 0, 4'b0100, 2'd2, 1, 0, "rr_g2");
        step(1, 4'b1111, 1, 4'b0000, 2'd0, 0, 0, "rr_i2");
        step(1, 4'b1111, 0, 4'b1000, 2'd3, 1, 0, "rr_g3");
        step(1, 4'b1111, 1, 4'b0000, 2'd0, 0, 0, "rr_i3");
        step(1, 4'b1111, 0, 4'b0001, 2'd0, 1, 0, "rr_wrap");
        step(1, 4'b0000, 1, 4'b0000, 2'd0, 0, 0, "rr_end");

        // hold limit: 4 cycles, timeout pulse, regrant
        step(0, 4'b0000, 0, 4'b0000, 2'd0, 0, 0, "rst_b");
        step(1, 4'b0100, 0, 4'b0100, 2'd2, 1, 0, "hold_c0");
        step(1, 4'b0100, 0, 4'b0100, 2'd2, 1, 0, "hold_c1");
        step(1, 4'b0100, 0, 4'b0100, 2'd2, 1, 0, "hold_c2");
        step(1, 4'b0100, 0, 4'b0100, 2'd2, 1, 0, "hold_c3");
        step(1, 4'b0100, 0, 4'b0000, 2'd0, 0, 1, "hold_timeout");
        step(1, 4'b0100, 0, 4'b0100, 2'd2, 1, 0, "hold_regrant");
        step(1, 4'b0000, 0, 4'b0000, 2'd0, 0, 0, "hold_drop");

        // owner drops req at hold cycle 2; non-owner changes ignored (ptr=3)
        step(1, 4'b0010, 0, 4'b0010, 2'd1, 1, 0, "drop_c0");
        step(1, 4'b1010, 0, 4'b0010, 2'd1, 1, 0, "drop_c1_nonowner");
        step(1, 4'b0011, 0, 4'b0010, 2'd1, 1, 0, "drop_c2");
        step(1, 4'b0000, 0, 4'b0000, 2'd0, 0, 0, "drop_release");

        // reset during grant of port 3 (ptr=2), then ptr restarts at 0
        step(1, 4'b1000, 0, 4'b1000, 2'd3, 1, 0, "pre_rst_g3");
        step(0, 4'b1010, 0, 4'b0000, 2'd0, 0, 0, "rst_in_grant");
        step(1, 4'b1010, 0, 4'b0010, 2'd1, 1, 0, "post_rst_ptr0");
        step(1, 4'b1010, 1, 4'b0000, 2'd0, 0, 0, "post_rst_done");

        // done coincides with hold limit: no timeout
        step(0, 4'b0000, 0, 4'b0000, 2'd0, 0, 0, "rst_c");
        step(1, 4'b0001, 0, 4'b0001, 2'd0, 1, 0, "lim_c0");
        step(1, 4'b0001, 0, 4'b0001, 2'd0, 1, 0, "lim_c1");
        step(1, 4'b0001, 0, 4'b0001, 2'd0, 1, 0, "lim_c2");
        step(1, 4'b0001, 0, 4'b0001, 2'd0, 1, 0, "lim_c3");
        step(1, 4'b0001, 1, 4'b0000, 2'd0, 0, 0, "lim_done_no_to");

        // req drop coincides with hold limit: no timeout (ptr=1)
        step(1, 4'b0010, 0, 4'b0010, 2'd1, 1, 0, "lim2_c0");
        step(1, 4'b0010, 0, 4'b0010, 2'd1, 1, 0, "lim2_c1");
        step(1, 4'b0010, 0, 4'b0010, 2'd1, 1, 0, "lim2_c2");
        step(1, 4'b0010, 0, 4'b0010, 2'd1, 1, 0, "lim2_c3");
        step(1, 4'b0000, 0, 4'b0000, 2'd0, 0, 0, "lim2_drop_no_to");
        step(1, 4'b0000, 0, 4'b0000, 2'd0, 0, 0, "final_idle");

        // drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            tests_failed++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
